// File: rtl/usb_tx_pkt.sv
// usb_tx_pkt: arbitrates handshake and data requesters, sequencing PID, payload and CRC16 bytes into the USB byte sender
module usb_tx_pkt #(
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs_req,
  input  logic [3:0] hs_pid,
  output logic       hs_done,
  input  logic       dat_req,
  input  logic [3:0] dat_pid,
  input  logic [3:0] dat_len,
  input  logic [7:0] dat_byte,
  output logic       dat_rd,
  output logic       dat_done,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_active
);
  typedef enum logic [2:0] {IDLE, PID, PAYLOAD, CRC_LO, CRC_HI, LAST, EOP, DONE} state_t;
  localparam logic [3:0] MAX = 4'(MAX_LEN);
  state_t state, state_n;
  logic [3:0] pid, len, cnt;
  logic [15:0] crc;
  logic is_hs, act_q, grant;
  logic [3:0] len_c;
  assign grant = state == IDLE && (hs_req || dat_req);
  assign len_c = dat_len > MAX ? MAX : dat_len;
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state, byte mux, consume strobe and completion pulses
  always_comb begin
    state_n = state;
    tx_data = 8'h00;
    dat_rd = 1'b0;
    hs_done = 1'b0;
    dat_done = 1'b0;
    case (state)
      IDLE:    state_n = grant ? PID : IDLE;
      PID: begin
        tx_data = {~pid, pid};
        if (tx_ready) state_n = is_hs ? LAST : (len == 4'd0 ? CRC_LO : PAYLOAD);
      end
      PAYLOAD: begin
        tx_data = dat_byte;
        dat_rd = tx_ready;
        if (tx_ready && cnt + 4'd1 == len) state_n = CRC_LO;
      end
      CRC_LO: begin
        tx_data = ~crc[7:0];
        if (tx_ready) state_n = CRC_HI;
      end
      CRC_HI: begin
        tx_data = ~crc[15:8];
        if (tx_ready) state_n = LAST;
      end
      LAST:    state_n = tx_ready ? EOP : LAST;
      EOP:     state_n = (act_q && !tx_active) ? DONE : EOP;
      DONE: begin
        hs_done = is_hs;
        dat_done = !is_hs;
        state_n = IDLE;
      end
    endcase
  end
  // grant capture, CRC accumulation, byte count and the sender valid line
  always_ff @(posedge clk)
    if (reset) begin
      tx_valid <= 1'b0;
      crc <= 16'hFFFF;
      cnt <= 4'd0;
      pid <= 4'd0;
      len <= 4'd0;
      is_hs <= 1'b0;
      act_q <= 1'b0;
    end else begin
      act_q <= tx_active;
      if (grant) begin
        is_hs <= hs_req;
        pid <= hs_req ? hs_pid : dat_pid;
        len <= hs_req ? 4'd0 : len_c;
        crc <= 16'hFFFF;
        cnt <= 4'd0;
        tx_valid <= 1'b1;
      end
      if (state == PAYLOAD && tx_ready) begin
        crc <= crc16_byte(crc, dat_byte);
        cnt <= cnt + 4'd1;
      end
      if (state == LAST && tx_ready) tx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_usb_tx_pkt.sv
// tb_usb_tx_pkt: randomized packet traffic against a byte-stream model of the USB packet sequencer
module tb_usb_tx_pkt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hs_req = 1'b0, dat_req = 1'b0;
  logic [3:0] hs_pid = 4'd0, dat_pid = 4'd0, dat_len = 4'd0;
  logic [7:0] dat_byte, tx_data;
  logic dat_rd, hs_done, dat_done, tx_valid;
  logic tx_ready = 1'b0, tx_active = 1'b0;
  logic ptr_clr = 1'b0;
  logic [7:0] pbuf [16];
  int ptr = 0;
  int checks = 0, fails = 0;
  logic [7:0] exp_q[$];
  int n_q[$];
  int len_q[$];
  bit hs_q[$];
  logic [7:0] cur_b [16];
  int cur_n = 0, cur_len = 0, pulse_k = 0, last_pulses = 0;
  bit cur_hs = 1'b0;
  logic [7:0] cap[$];
  int rd_total = 0, hs_total = 0, dat_total = 0;
  bit chk_en = 1'b1;

  usb_tx_pkt #(.MAX_LEN(8)) dut (
    .clk(clk), .reset(reset),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
    .dat_req(dat_req), .dat_pid(dat_pid), .dat_len(dat_len),
    .dat_byte(dat_byte), .dat_rd(dat_rd), .dat_done(dat_done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  assign dat_byte = ptr < 16 ? pbuf[ptr] : 8'h00;
  always @(posedge clk) ptr <= ptr_clr ? 0 : (dat_rd ? ptr + 1 : ptr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // USB CRC16 over the LSB-first bit stream using a plain MSB-first shift register, result mirrored and inverted
  function automatic logic [15:0] crc_tx(input logic [7:0] b [16], input int n);
    logic [15:0] c, r;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[15] ^ b[i][j];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    for (int j = 0; j < 16; j++) r[j] = c[15 - j];
    return ~r;
  endfunction

  task automatic push_pkt(input bit hs, input logic [3:0] pid, input int len);
    int l;
    logic [15:0] c;
    l = hs ? 0 : (len > 8 ? 8 : len);
    exp_q.push_back({~pid, pid});
    if (!hs) begin
      for (int i = 0; i < l; i++) exp_q.push_back(pbuf[i]);
      c = crc_tx(pbuf, l);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
    hs_q.push_back(hs);
    len_q.push_back(l);
    n_q.push_back(hs ? 1 : l + 3);
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (hs_done || dat_done) got = 1'b1;
    end
  endtask

  task automatic clear_ptr();
    ptr_clr = 1'b1;
    @(posedge clk); #1;
    ptr_clr = 1'b0;
  endtask

  task automatic run_pkt(input bit hs, input logic [3:0] pid, input int len, input bit drop);
    int l, n, cap0, rd0, hs0, dat0;
    bit got;
    l = hs ? 0 : (len > 8 ? 8 : len);
    n = hs ? 1 : l + 3;
    cap0 = cap.size(); rd0 = rd_total; hs0 = hs_total; dat0 = dat_total;
    clear_ptr();
    push_pkt(hs, pid, len);
    if (hs) begin
      hs_req = 1'b1; hs_pid = pid;
    end else begin
      dat_req = 1'b1; dat_pid = pid; dat_len = 4'(len);
    end
    if (drop) begin
      for (int i = 0; i < 20 && !tx_valid; i++) begin @(posedge clk); #1; end
      hs_req = 1'b0; dat_req = 1'b0;
    end
    wait_done(got);
    @(posedge clk); #1;
    hs_req = 1'b0; dat_req = 1'b0;
    chk("done_seen", got, 1);
    chk("hs_done_count", hs_total - hs0, hs ? 1 : 0);
    chk("dat_done_count", dat_total - dat0, hs ? 0 : 1);
    chk("ready_pulses", last_pulses, n + 1);
    chk("captured_bytes", cap.size() - cap0, n + 1);
    chk("dat_rd_count", rd_total - rd0, l);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
  endtask

  // byte sender: waits for valid, pulses ready at irregular intervals, then holds the bus through EOP
  initial begin : sender
    bit stop, aborted;
    int gap;
    forever begin
      @(posedge clk); #1;
      if (tx_valid === 1'b1) begin
        if (n_q.size() > 0) begin
          cur_hs = hs_q.pop_front();
          cur_len = len_q.pop_front();
          cur_n = n_q.pop_front();
          for (int i = 0; i < cur_n; i++) cur_b[i] = exp_q.pop_front();
        end else begin
          cur_hs = 1'b0; cur_len = 0; cur_n = 0;
        end
        pulse_k = 0;
        tx_active = 1'b1;
        stop = 1'b0;
        while (!stop) begin
          aborted = 1'b0;
          gap = $urandom_range(1, 6);
          for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            if (!tx_valid) aborted = 1'b1;
          end
          if (aborted) stop = 1'b1;
          else begin
            pulse_k++;
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
            if (!tx_valid) stop = 1'b1;
          end
        end
        last_pulses = pulse_k;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1;
        tx_active = 1'b0;
      end
    end
  end

  // per-cycle comparison of the byte handshake against the expected packet
  initial begin : compare
    bit prev_pulse;
    int prev_k;
    prev_pulse = 1'b0;
    prev_k = 0;
    forever begin
      @(negedge clk);
      if (chk_en && cur_n > 0) begin
        if (prev_pulse) chk("valid_after_ready", tx_valid, prev_k <= cur_n);
        if (tx_ready) begin
          if (pulse_k <= cur_n) chk("tx_byte", tx_data, cur_b[pulse_k - 1]);
          chk("dat_rd_on_ready", dat_rd, !cur_hs && pulse_k >= 2 && pulse_k <= cur_len + 1);
          chk("valid_while_ready", tx_valid, 1);
        end else chk("dat_rd_idle", dat_rd, 0);
      end
      if (tx_ready) cap.push_back(tx_data);
      if (dat_rd) rd_total++;
      if (hs_done) hs_total++;
      if (dat_done) dat_total++;
      prev_pulse = tx_ready;
      prev_k = pulse_k;
    end
  end

  initial begin : main
    logic [7:0] s9 [16];
    int c0, rd0, hs0, dat0;
    bit got, hs;
    int k;
    logic [3:0] pid;
    for (int i = 0; i < 16; i++) begin
      pbuf[i] = 8'h00;
      s9[i] = 8'h31 + 8'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_hs_done", hs_done, 0);
    chk("reset_dat_done", dat_done, 0);
    reset = 1'b0;
    chk("crc_model_check_str", crc_tx(s9, 9), 16'hB4C8);
    chk("crc_model_empty", crc_tx(s9, 0), 16'h0000);

    c0 = cap.size();
    run_pkt(1'b1, 4'b0010, 0, 1'b0);
    chk("ack_pid_byte", cap[c0], 8'hD2);

    c0 = cap.size();
    run_pkt(1'b0, 4'b0011, 0, 1'b0);
    chk("data0_len0_b0", cap[c0], 8'hC3);
    chk("data0_len0_b1", cap[c0 + 1], 8'h00);
    chk("data0_len0_b2", cap[c0 + 2], 8'h00);

    pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03;
    c0 = cap.size();
    run_pkt(1'b0, 4'b1011, 3, 1'b0);
    chk("data1_pid", cap[c0], 8'h4B);
    chk("data1_p0", cap[c0 + 1], 8'h01);
    chk("data1_p1", cap[c0 + 2], 8'h02);
    chk("data1_p2", cap[c0 + 3], 8'h03);

    for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
    clear_ptr();
    hs0 = hs_total; dat0 = dat_total; rd0 = rd_total;
    push_pkt(1'b1, 4'b1010, 0);
    push_pkt(1'b0, 4'b1011, 5);
    hs_req = 1'b1; hs_pid = 4'b1010;
    dat_req = 1'b1; dat_pid = 4'b1011; dat_len = 4'd5;
    wait_done(got);
    chk("both_first_done_seen", got, 1);
    chk("both_first_is_hs", hs_done, 1);
    chk("both_first_not_dat", dat_done, 0);
    hs_req = 1'b0;
    @(negedge clk);
    chk("both_idle_gap_valid", tx_valid, 0);
    @(negedge clk);
    chk("both_data_granted", tx_valid, 1);
    wait_done(got);
    @(posedge clk); #1;
    dat_req = 1'b0;
    chk("both_second_done_seen", got, 1);
    chk("both_hs_count", hs_total - hs0, 1);
    chk("both_dat_count", dat_total - dat0, 1);
    chk("both_rd_count", rd_total - rd0, 5);

    for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
    run_pkt(1'b0, 4'b0011, 12, 1'b0);

    for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
    clear_ptr();
    hs0 = hs_total; dat0 = dat_total; rd0 = rd_total;
    push_pkt(1'b0, 4'b0011, 8);
    dat_req = 1'b1; dat_pid = 4'b0011; dat_len = 4'd8;
    for (int i = 0; i < 500 && rd_total < rd0 + 2; i++) begin @(posedge clk); #1; end
    chk("rst_reached_payload", rd_total >= rd0 + 2, 1);
    chk_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dat_req = 1'b0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_dat_rd", dat_rd, 0);
    for (int i = 0; i < 100 && tx_active; i++) begin @(posedge clk); #1; end
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_hs_done", hs_total - hs0, 0);
    chk("rst_no_dat_done", dat_total - dat0, 0);
    chk_en = 1'b1;
    c0 = cap.size();
    run_pkt(1'b1, 4'b0010, 0, 1'b0);
    chk("rst_ack_pid_byte", cap[c0], 8'hD2);

    for (int it = 0; it < 25; it++) begin
      hs = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 2);
      pid = hs ? (k == 0 ? 4'b0010 : (k == 1 ? 4'b1010 : 4'b1110)) : (k == 0 ? 4'b0011 : 4'b1011);
      for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
      run_pkt(hs, pid, $urandom_range(0, 12), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
